// File: rtl/pipelined_add_sub_if.sv
// Handshake bundle for pipelined_add_sub; the optional sat lane exists only
// when ADDSUB_SAT_EN is defined.
interface pipelined_add_sub_if #(
    parameter int M = 32
);
    // Both sides use valid/ready: a beat transfers on a rising edge where valid
    // and ready are both high; valid and its payload must stay steady until then.
    logic         inValid;
    logic         inReady;
    logic         sub;
    logic         cin;
    logic [M-1:0] x;
    logic [M-1:0] y;
`ifdef ADDSUB_SAT_EN
    logic         sat;
`endif
    logic         outValid;
    logic         outReady;
    logic [M-1:0] out;
    logic         cout;
    logic         v;

    modport master (
`ifdef ADDSUB_SAT_EN
        output sat,
`endif
        output inValid, sub, cin, x, y, outReady,
        input  inReady, outValid, out, cout, v
    );

    modport slave (
`ifdef ADDSUB_SAT_EN
        input  sat,
`endif
        input  inValid, sub, cin, x, y, outReady,
        output inReady, outValid, out, cout, v
    );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined M-bit add/sub, carry chain cut into S segments, one per stage.
// Optional feature macro: ADDSUB_SAT_EN adds per-transaction saturation.
module pipelined_add_sub #(
    parameter int M = 32,
    parameter int S = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipelined_add_sub_if.slave  bus
);
    localparam int W = M / S;

    logic [S-1:0] valid;
    logic [S-1:0] adv;

    // Ready ripples back from the output so a full pipe can still move every cycle.
    always_comb begin
        adv = '0;
        adv[S-1] = valid[S-1] & bus.outReady;
        for (int k = S - 2; k >= 0; k--) begin
            adv[k] = valid[k] & (~valid[k+1] | adv[k+1]);
        end
    end

    assign bus.inReady = ~valid[0] | adv[0];

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int LW = M - k * W;
        localparam int RW = (k + 1) * W;

        logic [LW-1:0] a_in;
        logic [LW-1:0] b_in;
        logic          c_in;
        logic          load;
        logic [W:0]    seg;
        logic [RW-1:0] r_raw;
        logic [RW-1:0] r_d;
        logic [RW-1:0] r_q;
        logic          c_q;
        logic          valid_q;
`ifdef ADDSUB_SAT_EN
        logic          sat_in;
`endif

        if (k == 0) begin : g_head
            assign a_in  = bus.x;
            assign b_in  = bus.sub ? ~bus.y : bus.y;
            assign c_in  = bus.cin ^ bus.sub;
            assign load  = bus.inValid & bus.inReady;
            assign r_raw = seg[W-1:0];
`ifdef ADDSUB_SAT_EN
            assign sat_in = bus.sat;
`endif
        end else begin : g_body
            assign a_in  = g_stage[k-1].g_ops.a_q;
            assign b_in  = g_stage[k-1].g_ops.b_q;
            assign c_in  = g_stage[k-1].c_q;
            assign load  = adv[k-1];
            assign r_raw = {seg[W-1:0], g_stage[k-1].r_q};
`ifdef ADDSUB_SAT_EN
            assign sat_in = g_stage[k-1].g_ops.sat_q;
`endif
        end

        assign seg = {1'b0, a_in[W-1:0]} + {1'b0, b_in[W-1:0]} + {{W{1'b0}}, c_in};
        assign valid[k] = valid_q;

        if (k < S - 1) begin : g_ops
            // Only the not-yet-consumed upper operand bits travel onward.
            logic [LW-W-1:0] a_q;
            logic [LW-W-1:0] b_q;
`ifdef ADDSUB_SAT_EN
            logic            sat_q;
`endif
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
`ifdef ADDSUB_SAT_EN
                    sat_q <= 1'b0;
`endif
                end else if (load) begin
                    a_q <= a_in[LW-1:W];
                    b_q <= b_in[LW-1:W];
`ifdef ADDSUB_SAT_EN
                    sat_q <= sat_in;
`endif
                end
            end
            assign r_d = r_raw;
        end else begin : g_tail
            logic c_msb;
            logic v_q;
            // Carry into the sign bit, recovered from the top segment's sum bit.
            assign c_msb = seg[W-1] ^ a_in[W-1] ^ b_in[W-1];
`ifdef ADDSUB_SAT_EN
            assign r_d = (sat_in && (c_msb ^ seg[W]))
                       ? {~r_raw[RW-1], {(RW-1){r_raw[RW-1]}}}
                       : r_raw;
`else
            assign r_d = r_raw;
`endif
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_q <= 1'b0;
                end else if (load) begin
                    v_q <= c_msb ^ seg[W];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                c_q     <= 1'b0;
                r_q     <= '0;
            end else begin
                valid_q <= load | (valid_q & ~adv[k]);
                if (load) begin
                    c_q <= seg[W];
                    r_q <= r_d;
                end
            end
        end
    end

    assign bus.outValid = valid[S-1];
    assign bus.out      = g_stage[S-1].r_q;
    assign bus.cout     = g_stage[S-1].c_q;
    assign bus.v        = g_stage[S-1].g_tail.v_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Self-checking bench for pipelined_add_sub: directed scenarios plus a
// randomised sweep with outReady toggling, checked through an in-order scoreboard.
module tb_pipelined_add_sub;
    localparam int M = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic cur_sat = 1'b0;
    bit   done = 1'b0;
    logic [M+1:0] exp_q[$];

    pipelined_add_sub_if #(.M(M)) bus();

    pipelined_add_sub #(.M(M), .S(S)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [M+1:0] model(input logic [M-1:0] a, b,
                                           input logic s, c, st);
        logic [M-1:0] bb;
        logic [M:0]   full;
        logic [M-1:0] r;
        logic         ov;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{M{1'b0}}, c ^ s};
        r    = full[M-1:0];
        ov   = (a[M-1] == bb[M-1]) && (r[M-1] != a[M-1]);
`ifdef ADDSUB_SAT_EN
        if (st && ov) r = r[M-1] ? {1'b0, {(M-1){1'b1}}} : {1'b1, {(M-1){1'b0}}};
`else
        if (st && 1'b0) r = '0;
`endif
        return {full[M], ov, r};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [M+1:0] e;
        if (rst_n && bus.inValid && bus.inReady)
            exp_q.push_back(model(bus.x, bus.y, bus.sub, bus.cin, cur_sat));
        if (rst_n && bus.outValid && bus.outReady) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got out=%h cout=%b v=%b with nothing expected",
                         bus.out, bus.cout, bus.v);
            end else begin
                e = exp_q.pop_front();
                if ({bus.cout, bus.v, bus.out} !== e) begin
                    n_err++;
                    $display("FAIL sb_result: got cout=%b v=%b out=%h, want cout=%b v=%b out=%h",
                             bus.cout, bus.v, bus.out, e[M+1], e[M], e[M-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [M-1:0] xx, yy, input logic s, c, st);
        int guard;
        guard = 0;
        bus.x = xx; bus.y = yy; bus.sub = s; bus.cin = c; cur_sat = st;
`ifdef ADDSUB_SAT_EN
        bus.sat = st;
`endif
        bus.inValid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.inReady) break;
            @(posedge clk); #1;
            guard++;
            if (guard > 1000) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: inReady stayed 0 for %0d cycles, want 1", guard);
                bus.inValid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 100; g++) begin
            @(negedge clk);
            if (bus.outValid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [M-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(M-1){1'b0}}};
            3: return {1'b0, {(M-1){1'b1}}};
            default: return $urandom;
        endcase
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.inValid = 1'b0; bus.outReady = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL rst_outValid: got %b want 0", bus.outValid); end
        n_cmp++; if (bus.out !== '0) begin n_err++; $display("FAIL rst_out: got %h want 0", bus.out); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b want 0", bus.cout); end
        n_cmp++; if (bus.v !== 1'b0) begin n_err++; $display("FAIL rst_v: got %b want 0", bus.v); end
        n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL rst_inReady: got %b want 1", bus.inReady); end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap_add();
        bit ok;
        int t0;
        bus.outReady = 1'b1;
        send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        t0 = cyc;
        bus.inValid = 1'b0;
        wait_out(ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got no outValid want outValid"); end
        n_cmp++; if (cyc - t0 != S - 1) begin n_err++; $display("FAIL wrap_latency: got %0d edges want %0d", cyc - t0, S - 1); end
        n_cmp++; if (bus.out !== 32'h0) begin n_err++; $display("FAIL wrap_out: got %h want 00000000", bus.out); end
        n_cmp++; if (bus.cout !== 1'b1) begin n_err++; $display("FAIL wrap_cout: got %b want 1", bus.cout); end
        n_cmp++; if (bus.v !== 1'b0) begin n_err++; $display("FAIL wrap_v: got %b want 0", bus.v); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        bit ok;
        bus.outReady = 1'b1;
        send(32'h8000_0000, 32'h1, 1'b1, 1'b0, 1'b0);
        send(32'h5, 32'h5, 1'b1, 1'b0, 1'b0);
        bus.inValid = 1'b0;
        wait_out(ok);
        n_cmp++; if (!ok || bus.out !== 32'h7FFF_FFFF || bus.cout !== 1'b1 || bus.v !== 1'b1) begin
            n_err++; $display("FAIL sub_min: got out=%h cout=%b v=%b want out=7fffffff cout=1 v=1", bus.out, bus.cout, bus.v);
        end
        @(posedge clk); #1;
        wait_out(ok);
        n_cmp++; if (!ok || bus.out !== 32'h0 || bus.cout !== 1'b1 || bus.v !== 1'b0) begin
            n_err++; $display("FAIL sub_equal: got out=%h cout=%b v=%b want out=00000000 cout=1 v=0", bus.out, bus.cout, bus.v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int idx;
        logic [M-1:0] held;
        bit ok;
        bus.outReady = 1'b0;
        idx = 0;
        bus.x = 0; bus.y = 0; bus.sub = 1'b0; bus.cin = 1'b0; cur_sat = 1'b0;
`ifdef ADDSUB_SAT_EN
        bus.sat = 1'b0;
`endif
        bus.inValid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.inReady) begin
                @(posedge clk); #1;
                idx++;
                bus.x = idx; bus.y = idx;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        held = bus.out;
        n_cmp++; if (idx != S) begin n_err++; $display("FAIL bp_accepted: got %0d want %0d", idx, S); end
        n_cmp++; if (bus.inReady !== 1'b0) begin n_err++; $display("FAIL bp_inReady_low: got %b want 0", bus.inReady); end
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.outValid !== 1'b1 || bus.out !== held) begin
            n_err++; $display("FAIL bp_hold: got outValid=%b out=%h want outValid=1 out=%h", bus.outValid, bus.out, held);
        end
        @(posedge clk); #1;
        bus.outReady = 1'b1;
        #1;
        n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL bp_inReady_rise: got %b want 1", bus.inReady); end
        for (int i = idx; i < 6; i++) send(i, i, 1'b0, 1'b0, 1'b0);
        bus.inValid = 1'b0;
        for (int g = 0; g < 50 && exp_q.size() != 0; g++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: got %0d pending want 0", exp_q.size()); end
        wait_out(ok);
        n_cmp++; if (ok) begin n_err++; $display("FAIL bp_extra: got extra out=%h want none", bus.out); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.outReady = 1'b1;
        send(32'd10, 32'd20, 1'b0, 1'b0, 1'b0);
        send(32'd30, 32'd40, 1'b0, 1'b1, 1'b0);
        send(32'd50, 32'd60, 1'b1, 1'b0, 1'b0);
        bus.inValid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL mid_outValid: got %b want 0", bus.outValid); end
        n_cmp++; if (bus.out !== '0) begin n_err++; $display("FAIL mid_out: got %h want 0", bus.out); end
        n_cmp++; if (bus.inReady !== 1'b1) begin n_err++; $display("FAIL mid_inReady: got %b want 1", bus.inReady); end
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.outValid) seen++;
        end
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_stale: got %0d outputs want 0", seen); end
        @(posedge clk); #1;
    endtask

    task automatic test_sat();
        bit ok;
        bus.outReady = 1'b1;
`ifdef ADDSUB_SAT_EN
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        bus.inValid = 1'b0;
        wait_out(ok);
        n_cmp++; if (!ok || bus.out !== 32'h7FFF_FFFF || bus.v !== 1'b1) begin
            n_err++; $display("FAIL sat_on: got out=%h v=%b want out=7fffffff v=1", bus.out, bus.v);
        end
        @(posedge clk); #1;
`endif
        send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        bus.inValid = 1'b0;
        wait_out(ok);
        n_cmp++; if (!ok || bus.out !== 32'h8000_0000 || bus.v !== 1'b1) begin
            n_err++; $display("FAIL sat_off: got out=%h v=%b want out=80000000 v=1", bus.out, bus.v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        done = 1'b0;
        fork
            begin
                repeat (300) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        bus.inValid = 1'b0;
                        @(posedge clk); #1;
                    end
                end
                bus.inValid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.outReady = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.outReady = 1'b1;
        for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.inValid = 1'b0; bus.outReady = 1'b1;
        bus.x = '0; bus.y = '0; bus.sub = 1'b0; bus.cin = 1'b0;
`ifdef ADDSUB_SAT_EN
        bus.sat = 1'b0;
`endif
        test_reset();
        test_wrap_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_sat();
        test_random();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL final_queue: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
